// File: rtl/ysyx_22040237_pc_gen_pkg.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040237_pc_gen_pkg                                                 |
// | Shared widths, reset PC, PC state encodings and helpers for pc_gen.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ysyx_22040237_pc_gen_pkg;

  localparam int          REG_WIDTH        = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [63:0] PC_INC           = 64'd4;

  typedef enum logic [1:0] {
    PC_STATE_BOOT  = 2'd0,
    PC_STATE_FETCH = 2'd1,
    PC_STATE_EXEC  = 2'd2,
    PC_STATE_HALT  = 2'd3
  } pc_state_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0] src;
    logic [REG_WIDTH-1:0] dst;
  } trace_entry_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [REG_WIDTH-1:0] sat_inc(input logic [REG_WIDTH-1:0] v);
    return (&v) ? v : v + {{(REG_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040237_pc_trace_buf.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040237_pc_trace_buf                                               |
// | Redirect trace ring buffer; index 0 reads the newest entry.              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040237_pc_trace_buf
  import ysyx_22040237_pc_gen_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [63:0]      src_i,
  input  logic [63:0]      dst_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [63:0]      src_o,
  output logic [63:0]      dst_o
);

  trace_entry_t     mem_q [DEPTH];
  trace_entry_t     mem_d [DEPTH];
  logic [IDX_W-1:0] wr_ptr_q;
  logic [IDX_W-1:0] wr_ptr_d;
  logic [IDX_W-1:0] rd_ptr;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en_i) begin
      mem_d[wr_ptr_d] = '{src: src_i, dst: dst_i};
      wr_ptr_d        = wr_ptr_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Write pointer points one past the newest entry.
  assign rd_ptr = wr_ptr_q - IDX_W'(1) - idx_i;
  assign src_o  = mem_q[rd_ptr].src;
  assign dst_o  = mem_q[rd_ptr].dst;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040237_pc_gen.sv
// +--------------------------------------------------------------------------+
// | ysyx_22040237_pc_gen                                                     |
// | Program-counter generator feeding the IFU via valid/ready handshake.     |
// | Optional redirect trace enabled by YSYX_22040237_PC_TRACE_EN.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ysyx_22040237_pc_gen
  import ysyx_22040237_pc_gen_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
`ifdef YSYX_22040237_PC_TRACE_EN
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [63:0]                    trace_src_o,
  output logic [63:0]                    trace_dst_o,
`endif
  output logic [63:0]                    pc_o,
  output logic                           pc_valid_o,
  input  logic                           pc_ready_i,
  input  logic                           commit_i,
  input  logic                           br_taken_i,
  input  logic [63:0]                    br_target_i,
  input  logic                           trap_i,
  input  logic [63:0]                    trap_vec_i,
  input  logic                           halt_i,
  output logic                           halt_o,
  output logic                           misalign_o,
  output logic [63:0]                    fetch_cnt_o
);

  if ((TRACE_DEPTH < 2) || ((TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("TRACE_DEPTH must be a power of two, at least 2");
  end

  pc_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cnt_q, cnt_d;
  logic        misalign_q, misalign_d;
  logic        redirect;

  // Redirect inputs only matter on a commit in EXEC; halt wins over everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    redirect   = 1'b0;
    case (state_q)
      PC_STATE_BOOT: begin
        state_d = PC_STATE_FETCH;
      end
      PC_STATE_FETCH: begin
        if (pc_ready_i) begin
          state_d = PC_STATE_EXEC;
          cnt_d   = sat_inc(cnt_q);
        end
      end
      PC_STATE_EXEC: begin
        if (commit_i) begin
          if (halt_i) begin
            state_d = PC_STATE_HALT;
          end else begin
            state_d = PC_STATE_FETCH;
            if (trap_i) begin
              redirect = 1'b1;
              pc_d     = trap_vec_i;
            end else if (br_taken_i) begin
              redirect = 1'b1;
              if (br_target_i[1]) begin
                pc_d       = trap_vec_i;
                misalign_d = 1'b1;
              end else begin
                pc_d = br_target_i & ~64'd1;
              end
            end else begin
              pc_d = pc_q + PC_INC;
            end
          end
        end
      end
      default: begin
        state_d = PC_STATE_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= PC_STATE_BOOT;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o        = pc_q;
  assign pc_valid_o  = (state_q == PC_STATE_FETCH);
  assign halt_o      = (state_q == PC_STATE_HALT);
  assign misalign_o  = misalign_q;
  assign fetch_cnt_o = cnt_q;

`ifdef YSYX_22040237_PC_TRACE_EN
  ysyx_22040237_pc_trace_buf #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (redirect),
    .src_i   (pc_q),
    .dst_i   (pc_d),
    .idx_i   (trace_idx_i),
    .src_o   (trace_src_o),
    .dst_o   (trace_dst_o)
  );
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_pc_gen.sv
// Directed self-checking bench for ysyx_22040237_pc_gen.
`default_nettype none

module tb_ysyx_22040237_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_o;
  logic        pc_valid_o;
  logic        pc_ready_i;
  logic        commit_i;
  logic        br_taken_i;
  logic [63:0] br_target_i;
  logic        trap_i;
  logic [63:0] trap_vec_i;
  logic        halt_i;
  logic        halt_o;
  logic        misalign_o;
  logic [63:0] fetch_cnt_o;
`ifdef YSYX_22040237_PC_TRACE_EN
  logic [2:0]  trace_idx_i;
  logic [63:0] trace_src_o;
  logic [63:0] trace_dst_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ysyx_22040237_pc_gen dut (
    .clk         (clk),
    .rst         (rst),
`ifdef YSYX_22040237_PC_TRACE_EN
    .trace_idx_i (trace_idx_i),
    .trace_src_o (trace_src_o),
    .trace_dst_o (trace_dst_o),
`endif
    .pc_o        (pc_o),
    .pc_valid_o  (pc_valid_o),
    .pc_ready_i  (pc_ready_i),
    .commit_i    (commit_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .trap_i      (trap_i),
    .trap_vec_i  (trap_vec_i),
    .halt_i      (halt_i),
    .halt_o      (halt_o),
    .misalign_o  (misalign_o),
    .fetch_cnt_o (fetch_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmd();
    commit_i   = 1'b0;
    br_taken_i = 1'b0;
    trap_i     = 1'b0;
    halt_i     = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pc_ready_i = 1'b1;
    br_target_i = '0;
    trap_vec_i = 64'h8000_1000;
    clear_cmd();
`ifdef YSYX_22040237_PC_TRACE_EN
    trace_idx_i = 3'd0;
`endif
    step();
    step();
    check("rst_pc", pc_o, 64'h8000_0000);
    check("rst_valid", {63'd0, pc_valid_o}, 64'd0);
    check("rst_halt", {63'd0, halt_o}, 64'd0);
    check("rst_misalign", {63'd0, misalign_o}, 64'd0);
    check("rst_cnt", fetch_cnt_o, 64'd0);

    rst = 1'b1;
    #1;
    check("boot_valid", {63'd0, pc_valid_o}, 64'd0);
    step();
    check("fetch1_valid", {63'd0, pc_valid_o}, 64'd1);
    check("fetch1_pc", pc_o, 64'h8000_0000);
    step();
    check("exec1_valid", {63'd0, pc_valid_o}, 64'd0);
    check("exec1_cnt", fetch_cnt_o, 64'd1);

    commit_i = 1'b1;
    step();
    clear_cmd();
    check("seq_pc2", pc_o, 64'h8000_0004);
    check("seq_valid2", {63'd0, pc_valid_o}, 64'd1);
    step();
    commit_i = 1'b1;
    step();
    clear_cmd();
    check("seq_pc3", pc_o, 64'h8000_0008);
    step();
    check("seq_cnt3", fetch_cnt_o, 64'd3);

    commit_i = 1'b1; br_taken_i = 1'b1; br_target_i = 64'h8000_0101;
    step();
    clear_cmd();
    check("br_pc", pc_o, 64'h8000_0100);
    check("br_misalign", {63'd0, misalign_o}, 64'd0);
    step();

    commit_i = 1'b1; trap_i = 1'b1; br_taken_i = 1'b1; br_target_i = 64'h8000_2000;
    step();
    clear_cmd();
    check("trap_pc", pc_o, 64'h8000_1000);
    step();

    trap_vec_i = 64'h8000_3000;
    commit_i = 1'b1; br_taken_i = 1'b1; br_target_i = 64'h8000_0002;
    step();
    clear_cmd();
    check("mis_pc", pc_o, 64'h8000_3000);
    check("mis_pulse", {63'd0, misalign_o}, 64'd1);
    step();
    check("mis_pulse_end", {63'd0, misalign_o}, 64'd0);

    commit_i = 1'b1; br_taken_i = 1'b1; br_target_i = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    clear_cmd();
    check("wrap_pre_pc", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    commit_i = 1'b1;
    step();
    clear_cmd();
    check("wrap_pc", pc_o, 64'h0);

    pc_ready_i = 1'b0; commit_i = 1'b1; br_taken_i = 1'b1; br_target_i = 64'h40;
    step();
    clear_cmd();
    check("fetch_commit_pc", pc_o, 64'h0);
    check("fetch_commit_valid", {63'd0, pc_valid_o}, 64'd1);
    check("fetch_stall_cnt", fetch_cnt_o, 64'd7);
    pc_ready_i = 1'b1;
    step();
    check("cnt8", fetch_cnt_o, 64'd8);

    commit_i = 1'b1; halt_i = 1'b1; br_taken_i = 1'b1; br_target_i = 64'h8000_0200;
    step();
    clear_cmd();
    check("halt_o", {63'd0, halt_o}, 64'd1);
    check("halt_valid", {63'd0, pc_valid_o}, 64'd0);
    check("halt_pc", pc_o, 64'h0);
    step();
    step();
    check("halt_sticky", {63'd0, halt_o}, 64'd1);
    check("halt_valid_later", {63'd0, pc_valid_o}, 64'd0);
    check("halt_cnt", fetch_cnt_o, 64'd8);

`ifdef YSYX_22040237_PC_TRACE_EN
    trace_idx_i = 3'd0;
    #1;
    check("trace0_src", trace_src_o, 64'h8000_3000);
    check("trace0_dst", trace_dst_o, 64'hFFFF_FFFF_FFFF_FFFC);
    trace_idx_i = 3'd1;
    #1;
    check("trace1_src", trace_src_o, 64'h8000_1000);
    check("trace1_dst", trace_dst_o, 64'h8000_3000);
    trace_idx_i = 3'd0;
`endif

    // Reset taken while in EXEC with a commit pending.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    check("rst2_exec_valid", {63'd0, pc_valid_o}, 64'd0);
    commit_i = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    clear_cmd();
    check("midrst_pc", pc_o, 64'h8000_0000);
    check("midrst_valid", {63'd0, pc_valid_o}, 64'd0);
    check("midrst_cnt", fetch_cnt_o, 64'd0);
    check("midrst_halt", {63'd0, halt_o}, 64'd0);
    step();
    check("midrst_fetch_valid", {63'd0, pc_valid_o}, 64'd1);
    check("midrst_fetch_pc", pc_o, 64'h8000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
